stopwatch_display_driver: RTL

//  Consumes the stopwatch core's seconds/milliseconds/status outputs and drives a 5-digit

---
 rtl/stopwatch_display_driver.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_display_driver.sv
// stopwatch_display_driver: periodically snapshots the stopwatch time and converts it to BCD
// with a serial double-dabble engine. It then scans the result onto a 5-digit common-anode
// 7-segment display as "SS.mmm".
module stopwatch_display_driver #(
  parameter int unsigned UPDATE_PERIOD = 50,
  parameter int unsigned SCAN_DIV      = 2,
  parameter int unsigned BLINK_HALF    = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [9:0] milliseconds,
  input  logic       status_led,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [4:0] an_n,
  output logic       busy
);

  localparam int unsigned UPD_W  = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  // Nibble code never produced by BCD conversion; renders as a dash.
  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [UPD_W-1:0]  upd_cnt_q, upd_cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [3:0]        shift_q, shift_d;
  // Chain layout: {bcd[11:0], binary[9:0]}; the captured binary value is the snapshot.
  logic [21:0]       sec_chain_q, sec_chain_d;
  logic [21:0]       ms_chain_q, ms_chain_d;
  logic              err_q, err_d;
  // Display nibbles: [4]=sec tens, [3]=sec units, [2]=ms hundreds, [1]=ms tens, [0]=ms units.
  logic [4:0][3:0]   disp_q, disp_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [4:0]        an_q, an_d;
  logic              busy_q, busy_d;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the chain left.
  function automatic logic [21:0] dd_step(input logic [21:0] v);
    logic [21:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[10 + 4*i +: 4] >= 4'd5) begin
        t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
      end else begin
        t[10 + 4*i +: 4] = t[10 + 4*i +: 4];
      end
    end
    return {t[20:0], 1'b0};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for a display nibble.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      DASH:    s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // FSM next state plus the snapshot / conversion / commit datapath.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sec_chain_d = sec_chain_q;
    ms_chain_d  = ms_chain_q;
    err_d       = err_q;
    disp_d      = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (upd_cnt_q == {UPD_W{1'b0}}) begin
          state_d     = ST_CONVERT;
          shift_d     = 4'd0;
          sec_chain_d = {12'd0, 4'd0, seconds};
          ms_chain_d  = {12'd0, milliseconds};
          err_d       = (seconds > 6'd59) || (milliseconds > 10'd999);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        sec_chain_d = dd_step(sec_chain_q);
        ms_chain_d  = dd_step(ms_chain_q);
        if (shift_q == 4'd9) begin
          state_d = ST_COMMIT;
          shift_d = 4'd0;
        end else begin
          shift_d = shift_q + 4'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (err_q) begin
          disp_d = {5{DASH}};
        end else begin
          disp_d = {sec_chain_q[17:14], sec_chain_q[13:10],
                    ms_chain_q[21:18], ms_chain_q[17:14], ms_chain_q[13:10]};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Update/scan/blink counters and the next values of the registered display outputs.
  always_comb begin
    upd_cnt_d     = upd_cnt_q;
    scan_cnt_d    = scan_cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (upd_cnt_q == UPD_W'(UPDATE_PERIOD - 1)) begin
      upd_cnt_d = {UPD_W{1'b0}};
    end else begin
      upd_cnt_d = upd_cnt_q + UPD_W'(1);
    end

    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = {SCAN_W{1'b0}};
      if (idx_q == 3'd4) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    end

    // Holding the blink counter cleared while running makes it restart lit on the falling edge.
    if (status_led) begin
      blink_cnt_d   = {BLK_W{1'b0}};
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d   = {BLK_W{1'b0}};
      blink_phase_d = !blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end

    // Outputs follow the next digit index and next display contents so that
    // a commit is visible in the very next cycle.
    an_d   = ~(5'b00001 << idx_d);
    seg_d  = seg_encode(disp_d[idx_d]);
    dp_d   = !((idx_d == 3'd3) && (status_led || !blink_phase_d));
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counter and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_cnt_q     <= {UPD_W{1'b0}};
      scan_cnt_q    <= {SCAN_W{1'b0}};
      idx_q         <= 3'd0;
      blink_cnt_q   <= {BLK_W{1'b0}};
      blink_phase_q <= 1'b0;
      shift_q       <= 4'd0;
      sec_chain_q   <= 22'd0;
      ms_chain_q    <= 22'd0;
      err_q         <= 1'b0;
      disp_q        <= 20'd0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= 5'h1F;
      busy_q        <= 1'b0;
    end else begin
      upd_cnt_q     <= upd_cnt_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shift_q       <= shift_d;
      sec_chain_q   <= sec_chain_d;
      ms_chain_q    <= ms_chain_d;
      err_q         <= err_d;
      disp_q        <= disp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      busy_q        <= busy_d;
    end
  end

  assign seg_n = seg_q;
  assign dp_n  = dp_q;
  assign an_n  = an_q;
  assign busy  = busy_q;

endmodule
